tlp_tx_framer: RTL and testbench
================================

# tlp_tx_framer

Slave end of the DMA TLP request interface. Grants one requesting master at a time, latches its header fields and accepts its 64-bit payload beats. Emits a complete, DW-packed PCIe TLP (header plus payload) on a 64-bit valid/ready stream toward the PCIe hard-core transmit port. Covers Memory Write 32/64 and Completion-with-Data.

## Interface

**Parameters**
- `COMPLETER_ID`, default 16'h0000: Bus/Dev/Fn inserted in CplD DW1[31:16].

**Ports**
- `clk` in 1: single clock.
- `reset_n` in 1: synchronous, active-low reset.
- `req_to_send` in 1: master requests a TLP slot.
- `grant` out 1: slot granted, held for the whole packet.
- `fmt_type` in 7: 7'h40 MWr32, 7'h60 MWr64, 7'h4A CplD.
- `length_in_dw` in 10: payload DWs; 0 encodes 1024.
- `src_rdy_n` in 1: master data valid, active-low.
- `dst_rdy_n` out 1: framer ready, active-low.
- `data` in 64: payload beat; DW 2i in [31:0], DW 2i+1 in [63:32].
- `address` in 62: byte address [63:2].
- `ldwbe_fdwbe` in 8: {last BE, first BE}.
- `attr` in 2: header Attr bits.
- `transaction_id` in 24: {requester ID[23:8], tag[7:0]}.
- `byte_count` in 13: CplD byte count; bit 12 is dropped, so 4096 encodes as 0.
- `lower_address` in 7: CplD lower address.
- `tx_tdata` out 64: output beat, DW order as for `data`.
- `tx_tkeep` out 2: per-DW valid.
- `tx_tvalid` out 1: output beat valid.
- `tx_tlast` out 1: last beat of TLP.
- `tx_tready` in 1: sink ready.

## Operation

**Master contract:** header fields stay stable from `req_to_send` rising until the last data beat is accepted.

**Header DWs** (H0 in [31:0] of beat 0):
- H0 = {1'b0, fmt_type, 1'b0, 3'b0, 4'b0, 2'b0, attr, 2'b0, len}.
- MWr H1 = {transaction_id, ldwbe_fdwbe}.
- MWr32 H2 = {address[31:2], 2'b0}.
- MWr64 H2 = address[63:32]; H3 = {address[31:2], 2'b0}.
- CplD H1 = {COMPLETER_ID, 3'b000, 1'b0, byte_count[11:0]}.
- CplD H2 = {transaction_id[23:8], transaction_id[7:0], 1'b0, lower_address}.

**Beat packing:**
- 4DW header: beats {H1,H0}, {H3,H2}, then payload beats passed through unchanged.
- 3DW header: beats {H1,H0}, {D0,H2}, then {D(2k+1),D(2k)} shifted by one DW. A 32-bit carry register holds the upper DW of each source beat.

**Counts:**
- Source beats = ceil(L/2), with L = 1024 when `length_in_dw` = 0.
- Output beats = ceil((H+L)/2), with H = 3 or 4.
- The final output beat has `tx_tkeep` = 2'b01 when H+L is odd, else 2'b11.
- `tx_tkeep` = 2'b11 on all other beats.

**FSM states:** IDLE, HDR0, HDR1, DATA, FLUSH.
- **IDLE:** when `req_to_send`=1, go to HDR0 and set `grant`=1 on the next edge. Latch all header fields into registers at that edge.
- **HDR0:** emit {H1,H0}; on output accept, go to HDR1.
- **HDR1:** emit the second header beat.
  - 4DW: on accept, go to DATA.
  - 3DW: `dst_rdy_n`=0. The beat is emitted only after source beat 0 is accepted, which supplies D0. Then go to DATA.
- **DATA:** `dst_rdy_n`=0 whenever the output stage can take a beat. Each accepted source beat produces one output beat. On the last source beat:
  - if a carried DW remains (3DW header with L even), go to FLUSH;
  - otherwise mark `tx_tlast` and go to IDLE.
- **FLUSH:** emit {32'h0, carry} with `tx_tkeep`=01 and `tx_tlast`=1, then go to IDLE.
- A packet whose last source beat is consumed in HDR1 (3DW, L≤1) ends there with `tx_tlast`.

**Grant release:**
- `grant` drops on the edge after the last source beat is accepted. In FLUSH it is already low.
- IDLE lasts at least one cycle between packets.

**Unsupported `fmt_type`:** treated as MWr32 framing. No error reporting is provided.

**Reset** (`reset_n`=0 at an edge, also mid-packet):
- Packet is abandoned and the FSM returns to IDLE.
- Outputs: `grant`=0, `dst_rdy_n`=1, `tx_tvalid`=0, `tx_tlast`=0, `tx_tkeep`=2'b00, `tx_tdata`=0.
- Carry register and counters are cleared.

## Timing

- `tx_*` outputs are registered, through a single output stage with a skid slot.
- `dst_rdy_n` is low only when that stage will have room at the next edge, so no beat is dropped under `tx_tready` back-pressure.
- Beat accepted on the source side: `src_rdy_n`=0 and `dst_rdy_n`=0 at an edge.
- Beat accepted on the sink side: `tx_tvalid`=1 and `tx_tready`=1 at an edge.
- `tx_tvalid` stays high and `tx_tdata` stays stable until accepted.
- Latency:
  - `req_to_send` to `grant`: 1 cycle.
  - `grant` to first `tx_tvalid`: 1 cycle.
  - Source beat to output beat: 1 cycle.
- Throughput: one beat per cycle with `tx_tready` held at 1.
- Header fields are sampled only on the IDLE→HDR0 edge.

## Structure

- **`tlp_pkg`:** `fmt_type` constants (`FMT_MWR32`, `FMT_MWR64`, `FMT_CPLD`), FSM state enum, and the header-DW assembly functions. The package is shared with the `dmawr2tlp` master.
- **`tlp_tx_skid`:** one sub-module for the 64+2+1-bit output register with skid slot and valid/ready logic.
- **`tlp_tx_framer`:** FSM, header latch, carry register and beat counters.

## Test plan

1. MWr32, L=1, address 0x1000, data 0xDEADBEEF, BE 8'h0F. Expect 2 beats: {H1,H0} then {0xDEADBEEF, 0x00001000} with `tx_tkeep`=11 and `tx_tlast`=1.
2. MWr32, L=2, data {0x22222222, 0x11111111}. Expect 3 beats; last beat {0, 0x22222222}, `tx_tkeep`=01, `tx_tlast`=1 via FLUSH.
3. MWr64, L=4, address 0x1_0000_0040. Expect 4 beats: H2 = 0x00000001 and H3 = 0x00000040; payload passed through; last `tx_tkeep`=11.
4. CplD, L=1, byte_count 4, lower_address 7'h10, transaction_id 24'hABCD05. Expect H1[11:0]=4, H2 = 0xABCD0510, and 2 output beats.
5. MWr32, L=16, random `tx_tready` back-pressure and `src_rdy_n` gaps. Expect 10 beats, no loss or duplication, and a byte-exact match against the scoreboard.
6. `reset_n` pulsed low during DATA of an L=8 packet. Expect all outputs at reset values on the next edge; the next request is granted 1 cycle after `req_to_send`.

Source files
------------

// File: rtl/tlp_pkg.sv
// Shared TLP definitions for the DMA transmit path: fmt/type codes, framer
// FSM states and header-DW assembly helpers used by framer and master alike.
package tlp_pkg;

    localparam logic [6:0] FMT_MWR32 = 7'h40;
    localparam logic [6:0] FMT_MWR64 = 7'h60;
    localparam logic [6:0] FMT_CPLD  = 7'h4A;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        FLUSH
    } txState_t;

    function automatic logic [31:0] buildH0(input logic [6:0] fmtType,
                                            input logic [1:0] attrBits,
                                            input logic [9:0] lenDw);
        return {1'b0, fmtType, 1'b0, 3'b000, 4'b0000, 2'b00, attrBits, 2'b00, lenDw};
    endfunction

    function automatic logic [31:0] buildMwrH1(input logic [23:0] tid,
                                               input logic [7:0]  byteEnables);
        return {tid, byteEnables};
    endfunction

    function automatic logic [31:0] buildCplH1(input logic [15:0] cplId,
                                               input logic [11:0] byteCount);
        return {cplId, 3'b000, 1'b0, byteCount};
    endfunction

    function automatic logic [31:0] buildCplH2(input logic [23:0] tid,
                                               input logic [6:0]  lowAddr);
        return {tid[23:8], tid[7:0], 1'b0, lowAddr};
    endfunction

    function automatic logic [31:0] buildAddrLo(input logic [29:0] addrDw);
        return {addrDw, 2'b00};
    endfunction

endpackage

// File: rtl/tlp_tx_skid.sv
// Registered TX output stage with one skid slot; o_ready is a plain register
// decode so a beat pushed while the sink stalls always has somewhere to go.
module tlp_tx_skid (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_valid,
    input  logic [63:0] i_data,
    input  logic [1:0]  i_keep,
    input  logic        i_last,
    output logic        o_ready,
    output logic        o_txValid,
    output logic [63:0] o_txData,
    output logic [1:0]  o_txKeep,
    output logic        o_txLast,
    input  logic        i_txReady
);

    logic        r_outValid;
    logic [63:0] r_outData;
    logic [1:0]  r_outKeep;
    logic        r_outLast;
    logic        r_skidValid;
    logic [63:0] r_skidData;
    logic [1:0]  r_skidKeep;
    logic        r_skidLast;

    // Skid contents always drain into the output register before new input.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_outValid  <= 1'b0;
            r_outData   <= 64'd0;
            r_outKeep   <= 2'b00;
            r_outLast   <= 1'b0;
            r_skidValid <= 1'b0;
            r_skidData  <= 64'd0;
            r_skidKeep  <= 2'b00;
            r_skidLast  <= 1'b0;
        end else if (!r_outValid || i_txReady) begin
            if (r_skidValid) begin
                r_outValid  <= 1'b1;
                r_outData   <= r_skidData;
                r_outKeep   <= r_skidKeep;
                r_outLast   <= r_skidLast;
                r_skidValid <= 1'b0;
            end else begin
                r_outValid <= i_valid;
                r_outData  <= i_valid ? i_data : 64'd0;
                r_outKeep  <= i_valid ? i_keep : 2'b00;
                r_outLast  <= i_valid ? i_last : 1'b0;
            end
        end else if (i_valid && !r_skidValid) begin
            r_skidValid <= 1'b1;
            r_skidData  <= i_data;
            r_skidKeep  <= i_keep;
            r_skidLast  <= i_last;
        end
    end

    assign o_ready   = !r_skidValid;
    assign o_txValid = r_outValid;
    assign o_txData  = r_outData;
    assign o_txKeep  = r_outKeep;
    assign o_txLast  = r_outLast;

endmodule

// File: rtl/tlp_tx_framer.sv
// DMA TLP request slave: grants one master, latches its header, and frames
// MWr32/MWr64/CplD header plus DW-packed payload onto a 64-bit TX stream.
module tlp_tx_framer
    import tlp_pkg::*;
#(
    parameter logic [15:0] COMPLETER_ID = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_to_send,
    output logic        grant,
    input  logic [6:0]  fmt_type,
    input  logic [9:0]  length_in_dw,
    input  logic        src_rdy_n,
    output logic        dst_rdy_n,
    input  logic [63:0] data,
    input  logic [61:0] address,
    input  logic [7:0]  ldwbe_fdwbe,
    input  logic [1:0]  attr,
    input  logic [23:0] transaction_id,
    input  logic [12:0] byte_count,
    input  logic [6:0]  lower_address,
    output logic [63:0] tx_tdata,
    output logic [1:0]  tx_tkeep,
    output logic        tx_tvalid,
    output logic        tx_tlast,
    input  logic        tx_tready
);

    txState_t    r_state;
    txState_t    w_nextState;
    logic [31:0] r_hdr0, r_hdr1, r_hdr2, r_hdr3;
    logic        r_is4dw;
    logic        r_lenOdd;
    logic [9:0]  r_srcLeft;
    logic [31:0] r_carry;

    logic        w_stageReady;
    logic        w_srcReady;
    logic        w_srcAccept;
    logic        w_lastSrc;
    logic        w_push;
    logic [63:0] w_pushData;
    logic [1:0]  w_pushKeep;
    logic        w_pushLast;
    logic        w_isCpl;
    logic        w_is64;
    logic [31:0] w_h1, w_h2;
    logic [9:0]  w_srcBeats;
    logic        w_unused;

    // Byte count 4096 wraps to 0 in the 12-bit CplD field.
    assign w_unused = byte_count[12];

    assign w_isCpl    = (fmt_type == FMT_CPLD);
    assign w_is64     = (fmt_type == FMT_MWR64);
    assign w_h1       = w_isCpl ? buildCplH1(COMPLETER_ID, byte_count[11:0])
                                : buildMwrH1(transaction_id, ldwbe_fdwbe);
    assign w_h2       = w_isCpl ? buildCplH2(transaction_id, lower_address)
                                : (w_is64 ? address[61:30] : buildAddrLo(address[29:0]));
    assign w_srcBeats = (length_in_dw == 10'd0) ? 10'd512
                        : ({1'b0, length_in_dw[9:1]} + {9'd0, length_in_dw[0]});

    assign w_lastSrc   = (r_srcLeft == 10'd1);
    assign w_srcAccept = w_srcReady && !src_rdy_n;
    assign dst_rdy_n   = !w_srcReady;
    assign grant       = (r_state == HDR0) || (r_state == HDR1) || (r_state == DATA);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hdr0    <= 32'd0;
            r_hdr1    <= 32'd0;
            r_hdr2    <= 32'd0;
            r_hdr3    <= 32'd0;
            r_is4dw   <= 1'b0;
            r_lenOdd  <= 1'b0;
            r_srcLeft <= 10'd0;
            r_carry   <= 32'd0;
        end else begin
            if (r_state == IDLE && req_to_send) begin
                r_hdr0    <= buildH0(fmt_type, attr, length_in_dw);
                r_hdr1    <= w_h1;
                r_hdr2    <= w_h2;
                r_hdr3    <= buildAddrLo(address[29:0]);
                r_is4dw   <= w_is64;
                r_lenOdd  <= length_in_dw[0];
                r_srcLeft <= w_srcBeats;
            end
            if (w_srcAccept) begin
                r_carry   <= data[63:32];
                r_srcLeft <= r_srcLeft - 10'd1;
            end
        end
    end

    // With a 3DW header every output beat borrows the previous source's upper DW.
    always_comb begin
        w_nextState = r_state;
        w_srcReady  = 1'b0;
        w_push      = 1'b0;
        w_pushData  = 64'd0;
        w_pushKeep  = 2'b11;
        w_pushLast  = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_to_send) w_nextState = HDR0;
            end
            HDR0: begin
                if (w_stageReady) begin
                    w_push      = 1'b1;
                    w_pushData  = {r_hdr1, r_hdr0};
                    w_nextState = HDR1;
                end
            end
            HDR1: begin
                if (r_is4dw) begin
                    if (w_stageReady) begin
                        w_push      = 1'b1;
                        w_pushData  = {r_hdr3, r_hdr2};
                        w_nextState = DATA;
                    end
                end else begin
                    w_srcReady = w_stageReady;
                    if (w_srcReady && !src_rdy_n) begin
                        w_push     = 1'b1;
                        w_pushData = {data[31:0], r_hdr2};
                        if (!w_lastSrc) begin
                            w_nextState = DATA;
                        end else if (r_lenOdd) begin
                            w_pushLast  = 1'b1;
                            w_nextState = IDLE;
                        end else begin
                            w_nextState = FLUSH;
                        end
                    end
                end
            end
            DATA: begin
                w_srcReady = w_stageReady;
                if (w_srcReady && !src_rdy_n) begin
                    w_push     = 1'b1;
                    w_pushData = r_is4dw ? data : {data[31:0], r_carry};
                    if (w_lastSrc) begin
                        if (r_is4dw || r_lenOdd) begin
                            w_pushLast  = 1'b1;
                            w_pushKeep  = (r_is4dw && r_lenOdd) ? 2'b01 : 2'b11;
                            w_nextState = IDLE;
                        end else begin
                            w_nextState = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (w_stageReady) begin
                    w_push      = 1'b1;
                    w_pushData  = {32'd0, r_carry};
                    w_pushKeep  = 2'b01;
                    w_pushLast  = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    tlp_tx_skid u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_valid   (w_push),
        .i_data    (w_pushData),
        .i_keep    (w_pushKeep),
        .i_last    (w_pushLast),
        .o_ready   (w_stageReady),
        .o_txValid (tx_tvalid),
        .o_txData  (tx_tdata),
        .o_txKeep  (tx_tkeep),
        .o_txLast  (tx_tlast),
        .i_txReady (tx_tready)
    );

endmodule

// File: tb/tb_tlp_tx_framer.sv
// Randomized bench for tlp_tx_framer: a DW-list reference model builds the
// expected beat stream per packet and a negedge monitor scores the TX output.
module tb_tlp_tx_framer;

    localparam logic [15:0] CPL_ID = 16'hBEEF;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  keep;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_to_send = 1'b0;
    logic        grant;
    logic [6:0]  fmt_type = 7'h40;
    logic [9:0]  length_in_dw = 10'd1;
    logic        src_rdy_n = 1'b1;
    logic        dst_rdy_n;
    logic [63:0] data = 64'd0;
    logic [61:0] address = 62'd0;
    logic [7:0]  ldwbe_fdwbe = 8'd0;
    logic [1:0]  attr = 2'd0;
    logic [23:0] transaction_id = 24'd0;
    logic [12:0] byte_count = 13'd0;
    logic [6:0]  lower_address = 7'd0;
    logic [63:0] tx_tdata;
    logic [1:0]  tx_tkeep;
    logic        tx_tvalid;
    logic        tx_tlast;
    logic        tx_tready = 1'b1;

    beat_t       expQ[$];
    logic [31:0] payDw [0:1023];
    int          checkCount = 0;
    int          failCount = 0;
    int          readyPct = 100;

    tlp_tx_framer #(.COMPLETER_ID(CPL_ID)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_to_send    (req_to_send),
        .grant          (grant),
        .fmt_type       (fmt_type),
        .length_in_dw   (length_in_dw),
        .src_rdy_n      (src_rdy_n),
        .dst_rdy_n      (dst_rdy_n),
        .data           (data),
        .address        (address),
        .ldwbe_fdwbe    (ldwbe_fdwbe),
        .attr           (attr),
        .transaction_id (transaction_id),
        .byte_count     (byte_count),
        .lower_address  (lower_address),
        .tx_tdata       (tx_tdata),
        .tx_tkeep       (tx_tkeep),
        .tx_tvalid      (tx_tvalid),
        .tx_tlast       (tx_tlast),
        .tx_tready      (tx_tready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: list every DW of the TLP, then cut the list into 2-DW beats.
    function automatic void buildExpected();
        logic [31:0] dw[$];
        logic [63:0] byteAddr;
        int          lenDw;
        int          nBeats;
        beat_t       b;
        byteAddr = {address, 2'b00};
        lenDw    = (length_in_dw == 10'd0) ? 1024 : int'(length_in_dw);
        dw.push_back({1'b0, fmt_type, 8'h00, 2'b00, attr, 2'b00, length_in_dw});
        if (fmt_type == 7'h4A) begin
            dw.push_back({CPL_ID, 4'h0, byte_count[11:0]});
            dw.push_back({transaction_id, 1'b0, lower_address});
        end else begin
            dw.push_back({transaction_id, ldwbe_fdwbe});
            if (fmt_type == 7'h60) dw.push_back(byteAddr[63:32]);
            dw.push_back({byteAddr[31:2], 2'b00});
        end
        for (int i = 0; i < lenDw; i++) dw.push_back(payDw[i]);
        nBeats = (dw.size() + 1) / 2;
        for (int i = 0; i < nBeats; i++) begin
            b.data[31:0] = dw[2*i];
            if (2*i + 1 < dw.size()) begin
                b.data[63:32] = dw[2*i + 1];
                b.keep        = 2'b11;
            end else begin
                b.data[63:32] = 32'd0;
                b.keep        = 2'b01;
            end
            b.last = (i == nBeats - 1);
            expQ.push_back(b);
        end
    endfunction

    // Score every beat the sink accepts at the coming rising edge.
    always @(negedge clk) begin
        if (tx_tvalid && tx_tready) begin
            if (expQ.size() == 0) begin
                checkOutput("extraBeat", 64'd1, 64'd0);
            end else begin
                beat_t e;
                e = expQ.pop_front();
                checkOutput("beatData",
                            {(e.keep[1] ? tx_tdata[63:32] : 32'd0), tx_tdata[31:0]}, e.data);
                checkOutput("beatKeep", 64'(tx_tkeep), 64'(e.keep));
                checkOutput("beatLast", 64'(tx_tlast), 64'(e.last));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tx_tready = ($urandom_range(0, 99) < readyPct);
        end
    end

    task automatic randomizeFields();
        address        = {$urandom(), $urandom()};
        ldwbe_fdwbe    = 8'($urandom());
        attr           = 2'($urandom());
        transaction_id = 24'($urandom());
        byte_count     = 13'($urandom());
        lower_address  = 7'($urandom());
        for (int i = 0; i < 1024; i++) payDw[i] = $urandom();
    endtask

    task automatic driveBeat(input int beat, input int nSrc, input int gapPct);
        if (beat < nSrc && $urandom_range(0, 99) >= gapPct) begin
            src_rdy_n = 1'b0;
            data      = {payDw[2*beat + 1], payDw[2*beat]};
        end else begin
            src_rdy_n = 1'b1;
            data      = {$urandom(), $urandom()};
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "Grant"}, 64'(grant), 64'd0);
        checkOutput({tag, "DstRdyN"}, 64'(dst_rdy_n), 64'd1);
        checkOutput({tag, "Valid"}, 64'(tx_tvalid), 64'd0);
        checkOutput({tag, "Last"}, 64'(tx_tlast), 64'd0);
        checkOutput({tag, "Keep"}, 64'(tx_tkeep), 64'd0);
        checkOutput({tag, "Data"}, tx_tdata, 64'd0);
    endtask

    // One packet: request, grant timing, source beats, drain; optional mid-packet reset.
    task automatic applyStimulus(input int gapPct, input int rdyPct, input int abortAfter);
        int lenDw;
        int nSrc;
        int beat;
        int cyc;
        bit acc;
        lenDw    = (length_in_dw == 10'd0) ? 1024 : int'(length_in_dw);
        nSrc     = (lenDw + 1) / 2;
        readyPct = rdyPct;
        buildExpected();
        @(posedge clk);
        #1;
        req_to_send = 1'b1;
        @(negedge clk);
        checkOutput("grantBeforeEdge", 64'(grant), 64'd0);
        @(posedge clk);
        #1;
        req_to_send = 1'b0;
        beat = 0;
        cyc  = 0;
        driveBeat(beat, nSrc, gapPct);
        while (beat < nSrc && cyc < 4000 && !(abortAfter >= 0 && beat >= abortAfter)) begin
            @(negedge clk);
            if (cyc == 0) begin
                checkOutput("grantLatency", 64'(grant), 64'd1);
                checkOutput("validBeforeHdr", 64'(tx_tvalid), 64'd0);
            end
            if (cyc == 1) checkOutput("firstValidLatency", 64'(tx_tvalid), 64'd1);
            acc = !src_rdy_n && !dst_rdy_n;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) beat++;
            driveBeat(beat, nSrc, gapPct);
        end
        if (abortAfter >= 0) begin
            src_rdy_n = 1'b1;
            reset_n   = 1'b0;
            @(posedge clk);
            #1;
            checkResetOutputs("midReset");
            reset_n = 1'b1;
            expQ.delete();
        end else begin
            src_rdy_n = 1'b1;
            checkOutput("srcBeats", 64'(beat), 64'(nSrc));
            checkOutput("grantRelease", 64'(grant), 64'd0);
            cyc = 0;
            while (expQ.size() != 0 && cyc < 4000) begin
                @(negedge clk);
                cyc++;
            end
            checkOutput("drain", 64'(expQ.size()), 64'd0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        reset_n = 1'b1;

        randomizeFields();
        fmt_type = 7'h40; length_in_dw = 10'd1; address = 62'(64'h1000 >> 2);
        ldwbe_fdwbe = 8'h0F; payDw[0] = 32'hDEADBEEF;
        applyStimulus(0, 100, -1);

        randomizeFields();
        fmt_type = 7'h40; length_in_dw = 10'd2;
        payDw[0] = 32'h11111111; payDw[1] = 32'h22222222;
        applyStimulus(0, 100, -1);

        randomizeFields();
        fmt_type = 7'h60; length_in_dw = 10'd4; address = 62'(64'h1_0000_0040 >> 2);
        applyStimulus(0, 100, -1);

        randomizeFields();
        fmt_type = 7'h4A; length_in_dw = 10'd1; byte_count = 13'd4;
        lower_address = 7'h10; transaction_id = 24'hABCD05;
        applyStimulus(0, 100, -1);

        randomizeFields();
        fmt_type = 7'h4A; length_in_dw = 10'd3; byte_count = 13'h1000;
        applyStimulus(20, 70, -1);

        randomizeFields();
        fmt_type = 7'h60; length_in_dw = 10'd0;
        applyStimulus(10, 80, -1);

        randomizeFields();
        fmt_type = 7'h40; length_in_dw = 10'd16;
        applyStimulus(30, 60, -1);

        randomizeFields();
        fmt_type = 7'h40; length_in_dw = 10'd8;
        applyStimulus(0, 100, 2);

        randomizeFields();
        fmt_type = 7'h60; length_in_dw = 10'd5;
        applyStimulus(0, 100, -1);

        for (int n = 0; n < 24; n++) begin
            randomizeFields();
            case ($urandom_range(0, 2))
                0:       fmt_type = 7'h40;
                1:       fmt_type = 7'h60;
                default: fmt_type = 7'h4A;
            endcase
            length_in_dw = 10'($urandom_range(1, 40));
            applyStimulus(25, 65, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
